// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The sequencer drives the master side; the datapath owns op and mem_ready.
interface multicycle_control_if #(
    parameter int STATE_W = 4
) ();
    logic [5:0]         op;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_src;
    logic [STATE_W-1:0] state;
    logic               illegal;

    modport master (
        input  op, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, state, illegal
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, state, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for a multicycle MIPS datapath (R-type, lw, sw, beq, addi, j)
// with a memory-ready handshake stretching the fetch and data-memory states.
module multicycle_control #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    multicycle_control_if.master        bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        BADOP  = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_q;
    logic       ready;
    logic       pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s;
    logic       ir_write_s, reg_write_s;
    logic       i_or_d_s, mem_to_reg_s, reg_dst_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, alu_op_s, pc_src_s;

    assign ready = USE_MEM_READY ? bus.mem_ready : 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == BADOP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        i_or_d_s        = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'd0;
        alu_op_s        = 2'd0;
        pc_src_s        = 2'd0;
        case (state_q)
            FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'd1;
                ir_write_s  = ready;
                pc_write_s  = ready;
                if (ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b_s = 2'd3;
                case (bus.op)
                    6'h00:        state_d = EXEC;
                    6'h23, 6'h2B: state_d = MEMADR;
                    6'h04:        state_d = BRANCH;
                    6'h08:        state_d = ADDIEX;
                    6'h02:        state_d = JUMP;
                    default:      state_d = BADOP;
                endcase
            end
            MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'd2;
                state_d     = (bus.op == 6'h23) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
                if (ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                mem_write_s = 1'b1;
                i_or_d_s    = 1'b1;
                if (ready) state_d = FETCH;
            end
            EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'd2;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'd1;
                pc_write_cond_s = 1'b1;
                pc_src_s        = 2'd1;
                state_d         = FETCH;
            end
            ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'd2;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                reg_write_s = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_write_s = 1'b1;
                pc_src_s   = 2'd2;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are gated by reset so FETCH's read/ir_write cannot fire while held.
    assign bus.pc_write      = pc_write_s      & ~reset;
    assign bus.pc_write_cond = pc_write_cond_s & ~reset;
    assign bus.mem_read      = mem_read_s      & ~reset;
    assign bus.mem_write     = mem_write_s     & ~reset;
    assign bus.ir_write      = ir_write_s      & ~reset;
    assign bus.reg_write     = reg_write_s     & ~reset;
    assign bus.i_or_d        = i_or_d_s;
    assign bus.mem_to_reg    = mem_to_reg_s;
    assign bus.reg_dst       = reg_dst_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.alu_op        = alu_op_s;
    assign bus.pc_src        = pc_src_s;
    assign bus.state         = STATE_W'(state_q);
    assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for the multicycle control sequencer: per-cycle table
// plus hand sequences for reset-clears-illegal and asynchronous reset in MEMWR.
module tb_multicycle_control;

    logic clock = 1'b0;
    logic reset;

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.USE_MEM_READY(1'b1), .STATE_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Control word: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src}
    localparam logic [15:0] C_FETCH_RDY  = 16'h9410;
    localparam logic [15:0] C_FETCH_WAIT = 16'h1010;
    localparam logic [15:0] C_RESET      = 16'h0010;
    localparam logic [15:0] C_DECODE     = 16'h0030;
    localparam logic [15:0] C_MEMADR     = 16'h0060;
    localparam logic [15:0] C_MEMRD      = 16'h3000;
    localparam logic [15:0] C_MEMWB      = 16'h0280;
    localparam logic [15:0] C_MEMWR      = 16'h2800;
    localparam logic [15:0] C_EXEC       = 16'h0048;
    localparam logic [15:0] C_ALUWB      = 16'h0180;
    localparam logic [15:0] C_BRANCH     = 16'h4045;
    localparam logic [15:0] C_ADDIEX     = 16'h0060;
    localparam logic [15:0] C_ADDIWB     = 16'h0080;
    localparam logic [15:0] C_JUMP       = 16'h8002;
    localparam logic [15:0] C_BADOP      = 16'h0000;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [15:0] ctrl_word();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src};
    endfunction

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [15:0] ctrl, input logic ill);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] st,
                         input logic [15:0] ctrl, input logic ill);
        logic [15:0] c;
        c = ctrl_word();
        n_vec++;
        if (bus.state !== st || c !== ctrl || bus.illegal !== ill) begin
            n_bad++;
            $display("FAIL %s: got state=%0d ctrl=%h illegal=%b, expected state=%0d ctrl=%h illegal=%b",
                     name, bus.state, c, bus.illegal, st, ctrl, ill);
        end
    endtask

    initial begin
        // R-type
        add(6'h00, 1'b1, 4'd0,  C_FETCH_RDY, 1'b0);
        add(6'h00, 1'b1, 4'd1,  C_DECODE,    1'b0);
        add(6'h00, 1'b0, 4'd6,  C_EXEC,      1'b0);
        add(6'h00, 1'b1, 4'd7,  C_ALUWB,     1'b0);
        // lw with two wait cycles in MEMRD
        add(6'h23, 1'b1, 4'd0,  C_FETCH_RDY, 1'b0);
        add(6'h23, 1'b1, 4'd1,  C_DECODE,    1'b0);
        add(6'h23, 1'b1, 4'd2,  C_MEMADR,    1'b0);
        add(6'h23, 1'b0, 4'd3,  C_MEMRD,     1'b0);
        add(6'h23, 1'b0, 4'd3,  C_MEMRD,     1'b0);
        add(6'h23, 1'b1, 4'd3,  C_MEMRD,     1'b0);
        add(6'h23, 1'b1, 4'd4,  C_MEMWB,     1'b0);
        // sw with three wait cycles in FETCH
        add(6'h2B, 1'b0, 4'd0,  C_FETCH_WAIT, 1'b0);
        add(6'h2B, 1'b0, 4'd0,  C_FETCH_WAIT, 1'b0);
        add(6'h2B, 1'b0, 4'd0,  C_FETCH_WAIT, 1'b0);
        add(6'h2B, 1'b1, 4'd0,  C_FETCH_RDY,  1'b0);
        add(6'h2B, 1'b1, 4'd1,  C_DECODE,     1'b0);
        add(6'h2B, 1'b0, 4'd2,  C_MEMADR,     1'b0);
        add(6'h2B, 1'b1, 4'd5,  C_MEMWR,      1'b0);
        // beq
        add(6'h04, 1'b1, 4'd0,  C_FETCH_RDY, 1'b0);
        add(6'h04, 1'b1, 4'd1,  C_DECODE,    1'b0);
        add(6'h04, 1'b1, 4'd8,  C_BRANCH,    1'b0);
        // j
        add(6'h02, 1'b1, 4'd0,  C_FETCH_RDY, 1'b0);
        add(6'h02, 1'b1, 4'd1,  C_DECODE,    1'b0);
        add(6'h02, 1'b1, 4'd11, C_JUMP,      1'b0);
        // unsupported opcode
        add(6'h3F, 1'b1, 4'd0,  C_FETCH_RDY, 1'b0);
        add(6'h3F, 1'b1, 4'd1,  C_DECODE,    1'b0);
        add(6'h3F, 1'b1, 4'd12, C_BADOP,     1'b1);
        // addi, illegal stays set; mem_ready low outside memory states is ignored
        add(6'h08, 1'b1, 4'd0,  C_FETCH_RDY, 1'b1);
        add(6'h08, 1'b0, 4'd1,  C_DECODE,    1'b1);
        add(6'h08, 1'b0, 4'd9,  C_ADDIEX,    1'b1);
        add(6'h08, 1'b1, 4'd10, C_ADDIWB,    1'b1);
        add(6'h08, 1'b0, 4'd0,  C_FETCH_WAIT, 1'b1);

        reset = 1'b1;
        bus.op = 6'h00;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1 check("reset_hold", 4'd0, C_RESET, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.op = vecs[i].op;
            bus.mem_ready = vecs[i].rdy;
            #1 check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].ill);
            @(negedge clock);
        end

        // Bring the machine to FETCH, then reach MEMWR and stall there.
        bus.mem_ready = 1'b1;
        bus.op = 6'h2B;
        #1 check("sw_fetch", 4'd0, C_FETCH_RDY, 1'b1);
        @(negedge clock);
        #1 check("sw_decode", 4'd1, C_DECODE, 1'b1);
        @(negedge clock);
        #1 check("sw_memadr", 4'd2, C_MEMADR, 1'b1);
        @(negedge clock);
        bus.mem_ready = 1'b0;
        #1 check("sw_memwr_wait", 4'd5, C_MEMWR, 1'b1);
        // Reset between edges must act immediately.
        #1 reset = 1'b1;
        #1 check("async_reset_memwr", 4'd0, C_RESET, 1'b0);
        @(negedge clock);
        bus.mem_ready = 1'b1;
        #1 check("reset_held_rdy", 4'd0, C_RESET, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        bus.op = 6'h04;
        #1 check("post_reset_fetch", 4'd0, C_FETCH_RDY, 1'b0);
        @(negedge clock);
        #1 check("post_reset_decode", 4'd1, C_DECODE, 1'b0);
        @(negedge clock);
        #1 check("post_reset_branch", 4'd8, C_BRANCH, 1'b0);
        @(negedge clock);
        #1 check("post_reset_back", 4'd0, C_FETCH_RDY, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: one shared memory, one ALU reused across steps, and IR/PC write enables.
- Replaces the per-opcode combinational control used in the single-cycle CPU.
- Supports R-type, lw, sw, beq, addi and j.
- Adds a memory-ready handshake so memory accesses may take multiple cycles.

Parameters:
- USE_MEM_READY, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is ignored and treated as 1.
- STATE_W, 4, width of the state debug output (must be at least 4).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- op  in  6  opcode field of the instruction register (instr[31:26])
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address select: 0=PC, 1=ALU result register
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-back data select: 1=memory data register, 0=ALU result register
- reg_dst  out  1  destination select: 1=rd, 0=rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  0=register B, 1=constant 4, 2=sign-extended immediate, 3=sign-extended immediate shifted left 2
- alu_op  out  2  0=add, 1=sub, 2=decode func field
- pc_src  out  2  0=ALU output, 1=ALU result register, 2=jump target
- state  out  STATE_W  current state encoding
- illegal  out  1  sticky unsupported-opcode flag

Behaviour:
- State encoding (fixed):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, BADOP=12
- Reset (asynchronous, active-high):
  - state=FETCH, illegal=0.
  - While reset is high, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are forced to 0.
  - Mux selects take their FETCH values.
- Outputs not listed for a state are 0.
- Per-state outputs and transitions:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0. ir_write=pc_write=mem_ready (Mealy qualifier). Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute). Next state by op:
    - 0x00 -> EXEC
    - 0x23 or 0x2B -> MEMADR
    - 0x04 -> BRANCH
    - 0x08 -> ADDIEX
    - 0x02 -> JUMP
    - any other op -> BADOP
  - MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. op=0x23 -> MEMRD, else -> MEMWR.
  - MEMRD: mem_read=1, i_or_d=1. Wait on mem_ready, then -> MEMWB.
  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH.
  - MEMWR: mem_write=1, i_or_d=1. Wait on mem_ready, then -> FETCH.
  - EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. -> ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1. -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0. -> ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
  - JUMP: pc_write=1, pc_src=2. -> FETCH.
  - BADOP: illegal is set to 1 (sticky until reset); no strobes. -> FETCH, so execution continues at PC+4.
- Instruction latency with mem_ready always 1:
  - lw = 5 cycles
  - sw, R-type, addi = 4 cycles
  - beq, j, bad opcode = 3 cycles
- Each memory state adds one cycle per cycle that mem_ready is low.
- mem_read/mem_write are held stable for the whole wait. mem_ready seen outside FETCH/MEMRD/MEMWR is ignored.
- op is sampled only in DECODE and MEMADR; the IR holds it stable from FETCH onward.
- Reset asserted mid-instruction: state returns to FETCH immediately, no partial write is issued after reset, and illegal clears.
- Outputs are combinational from the state register (plus mem_ready in FETCH only); no output depends on op.

Test Plan:
- Reset high, then release; mem_ready=1; IR op=0x00 -> state sequence 0,1,6,7,0; reg_write=1, reg_dst=1 in state 7 only; ir_write and pc_write each pulse one cycle in state 0.
- op=0x23, mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; mem_read=1 and i_or_d=1 held across all three MEMRD cycles; mem_to_reg=1 in state 4.
- op=0x2B, mem_ready=0 for 3 cycles in FETCH -> ir_write=0 during the wait, pulses once on the ready cycle; sequence continues 1,2,5,0; mem_write=1 only in state 5.
- op=0x04, then op=0x02 -> beq: 0,1,8,0 with pc_write_cond=1, pc_src=1, alu_op=1; j: 0,1,11,0 with pc_write=1, pc_src=2.
- op=0x3F -> DECODE goes to 12 then 0; illegal rises and stays 1 through a following op=0x08 instruction (0,1,9,10,0); asserting reset clears it.
- Assert reset during MEMWR with mem_ready=0 -> state=0 and mem_write=0 asynchronously, before the next clock edge.
